// File: rtl/io_out_port_bcd.sv
// io_out_port_bcd
//   Memory-mapped output port bank. It latches CPU store data written to three
//   consecutive word addresses. A single shared sequential double-dabble engine
//   converts each latched value to packed BCD. The engine serves ports
//   round-robin whenever their pending flags are set.
// Ports:
//   clock           rising-edge system clock
//   resetn          asynchronous active-low reset
//   addr            CPU data address; only addr[7:2] is decoded
//   datain          CPU store data
//   write_io_enable CPU store to I/O space this cycle
//   out_port0..2    raw latched port values
//   bcd_port0..2    packed BCD of each port, digit 0 in [3:0]
//   bcd_valid       bit k pulses for one cycle when bcd_portk updates
//   busy            high while the engine is converting or committing
module io_out_port_bcd #(
  parameter logic [5:0]  PORT_BASE  = 6'b100000,
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned BCD_DIGITS = 10
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [31:0]             addr,
  input  logic [IN_WIDTH-1:0]     datain,
  input  logic                    write_io_enable,
  output logic [IN_WIDTH-1:0]     out_port0,
  output logic [IN_WIDTH-1:0]     out_port1,
  output logic [IN_WIDTH-1:0]     out_port2,
  output logic [4*BCD_DIGITS-1:0] bcd_port0,
  output logic [4*BCD_DIGITS-1:0] bcd_port1,
  output logic [4*BCD_DIGITS-1:0] bcd_port2,
  output logic [2:0]              bcd_valid,
  output logic                    busy
);

  localparam int unsigned BW = 4 * BCD_DIGITS;
  localparam int unsigned CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state;
  logic [IN_WIDTH-1:0]   port_q [3];
  logic [BW-1:0]         bcd_q  [3];
  logic [2:0]            pending;
  logic [1:0]            rr;
  logic [1:0]            cur;
  logic [CW-1:0]         cnt;
  logic [IN_WIDTH-1:0]   snapshot;
  logic [BW-1:0]         scratch;

  logic [5:0]            offset;
  logic [2:0]            wr_hit;
  logic                  found;
  logic [1:0]            sel;
  logic [2:0]            pending_clr;
  logic [BW-1:0]         adj;
  logic                  unused_addr;

  assign unused_addr = ^{addr[31:8], addr[1:0]};

  // Offset of the word index from the bank base; only 0..2 are ports.
  assign offset = addr[7:2] - PORT_BASE;

  always_comb begin
    wr_hit = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      wr_hit[k] = write_io_enable && (offset == 6'(k));
    end
  end

  // Round-robin pick: the first pending port searching from rr+1 (mod 3).
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      idx = (32'(rr) + 1 + i) % 3;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = 2'(idx);
      end
    end
  end

  assign pending_clr = (state == IDLE && found) ? (3'b001 << sel) : 3'b000;

  // Double-dabble correction: add 3 to every digit >= 5 before the shift.
  always_comb begin
    adj = '0;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                  : scratch[4*d +: 4];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < 3; k++) begin
        port_q[k] <= '0;
        bcd_q[k]  <= '0;
      end
      state     <= IDLE;
      pending   <= '0;
      rr        <= 2'd2;
      cur       <= '0;
      cnt       <= '0;
      snapshot  <= '0;
      scratch   <= '0;
      bcd_valid <= '0;
      busy      <= 1'b0;
    end else begin
      bcd_valid <= '0;
      // A write in the same cycle as the load of that port re-arms it (set wins).
      pending   <= (pending & ~pending_clr) | wr_hit;
      for (int unsigned k = 0; k < 3; k++) begin
        if (wr_hit[k]) port_q[k] <= datain;
      end

      case (state)
        IDLE: begin
          if (found) begin
            snapshot <= port_q[sel];
            scratch  <= '0;
            cnt      <= '0;
            cur      <= sel;
            rr       <= sel;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch  <= {adj[BW-2:0], snapshot[IN_WIDTH-1]};
          snapshot <= snapshot << 1;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(IN_WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          bcd_q[cur]     <= scratch;
          bcd_valid[cur] <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_port0 = port_q[0];
  assign out_port1 = port_q[1];
  assign out_port2 = port_q[2];
  assign bcd_port0 = bcd_q[0];
  assign bcd_port1 = bcd_q[1];
  assign bcd_port2 = bcd_q[2];

endmodule

// File: tb/tb_io_out_port_bcd.sv
// tb_io_out_port_bcd
//   Self-checking bench for io_out_port_bcd. The reference model holds the
//   last value stored to each port. It derives the BCD digits by repeated
//   division by ten. Each scenario lives in its own task.
module tb_io_out_port_bcd;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] datain = '0;
  logic        write_io_enable = 1'b0;
  logic [31:0] out_port0, out_port1, out_port2;
  logic [39:0] bcd_port0, bcd_port1, bcd_port2;
  logic [2:0]  bcd_valid;
  logic        busy;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_val [3];

  io_out_port_bcd #(.PORT_BASE(6'b100000), .IN_WIDTH(32), .BCD_DIGITS(10)) dut (
    .clock(clock), .resetn(resetn), .addr(addr), .datain(datain),
    .write_io_enable(write_io_enable),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
    .bcd_port0(bcd_port0), .bcd_port1(bcd_port1), .bcd_port2(bcd_port2),
    .bcd_valid(bcd_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    logic [39:0] r;
    logic [31:0] x;
    r = '0;
    x = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [39:0] bcd_of(input int k);
    return (k == 0) ? bcd_port0 : (k == 1) ? bcd_port1 : bcd_port2;
  endfunction

  function automatic logic [31:0] out_of(input int k);
    return (k == 0) ? out_port0 : (k == 1) ? out_port1 : out_port2;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One store cycle. The model sees it only when it hits word index 0x20..0x22.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic en);
    logic [5:0] w;
    addr = a; datain = d; write_io_enable = en;
    tick();
    write_io_enable = 1'b0;
    w = a[7:2];
    if (en && w >= 6'h20 && w <= 6'h22) exp_val[w - 6'h20] = d;
  endtask

  task automatic test_reset();
    total++; if ({out_port0, out_port1, out_port2} !== '0) $display("FAIL reset_out: got %h want 0", {out_port0, out_port1, out_port2}); else passed++;
    total++; if ({bcd_port0, bcd_port1, bcd_port2} !== '0) $display("FAIL reset_bcd: got %h want 0", {bcd_port0, bcd_port1, bcd_port2}); else passed++;
    total++; if ({bcd_valid, busy} !== 4'b0) $display("FAIL reset_valid_busy: got %b want 0000", {bcd_valid, busy}); else passed++;
  endtask

  task automatic test_single();
    wr(32'h80, 32'd57, 1'b1);
    total++; if (out_port0 !== 32'd57) $display("FAIL single_out: got %0d want 57", out_port0); else passed++;
    tick();
    total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else passed++;
    repeat (32) begin
      tick();
      if (bcd_valid !== 3'b000) begin
        total++; $display("FAIL single_early_valid: got %b want 000", bcd_valid);
      end
    end
    tick();
    total++; if (bcd_valid !== 3'b001) $display("FAIL single_valid: got %b want 001", bcd_valid); else passed++;
    total++; if (bcd_port0 !== to_bcd(32'd57)) $display("FAIL single_bcd: got %h want %h", bcd_port0, to_bcd(32'd57)); else passed++;
    tick();
    total++; if (bcd_valid !== 3'b000) $display("FAIL single_valid_len: got %b want 000", bcd_valid); else passed++;
  endtask

  task automatic test_max();
    bit got = 0;
    wr(32'h88, 32'hFFFF_FFFF, 1'b1);
    for (int c = 0; c < 60 && !got; c++) begin
      tick();
      if (bcd_valid !== 3'b000) begin
        got = 1;
        total++; if (bcd_valid !== 3'b100) $display("FAIL max_valid: got %b want 100", bcd_valid); else passed++;
      end
    end
    total++; if (!got) $display("FAIL max_timeout: got no pulse want pulse"); else passed++;
    total++; if (bcd_port2 !== 40'h4294967295) $display("FAIL max_bcd: got %h want 4294967295", bcd_port2); else passed++;
    total++; if (bcd_port0 !== to_bcd(exp_val[0]) || bcd_port1 !== to_bcd(exp_val[1]))
      $display("FAIL max_others: got %h/%h want %h/%h", bcd_port0, bcd_port1, to_bcd(exp_val[0]), to_bcd(exp_val[1]));
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  order [$];
    logic [39:0] vals  [$];
    logic [31:0] want  [3];
    want[0] = 32'd1; want[1] = 32'd22; want[2] = 32'd333;
    wr(32'h80, want[0], 1'b1);
    wr(32'h84, want[1], 1'b1);
    wr(32'h88, want[2], 1'b1);
    for (int c = 0; c < 150; c++) begin
      tick();
      if (bcd_valid !== 3'b000) begin
        order.push_back(bcd_valid);
        vals.push_back(bcd_valid[0] ? bcd_port0 : bcd_valid[1] ? bcd_port1 : bcd_port2);
      end
    end
    total++; if (order.size() != 3) $display("FAIL b2b_count: got %0d want 3", order.size()); else passed++;
    for (int i = 0; i < 3 && i < order.size(); i++) begin
      total++; if (order[i] !== (3'b001 << i)) $display("FAIL b2b_order%0d: got %b want %b", i, order[i], 3'b001 << i); else passed++;
      total++; if (vals[i] !== to_bcd(want[i])) $display("FAIL b2b_val%0d: got %h want %h", i, vals[i], to_bcd(want[i])); else passed++;
    end
  endtask

  task automatic test_rewrite();
    logic [39:0] vals [$];
    wr(32'h84, 32'd123, 1'b1);
    repeat (9) tick();
    wr(32'h84, 32'd99, 1'b1);
    for (int c = 0; c < 150; c++) begin
      tick();
      if (bcd_valid[1]) vals.push_back(bcd_port1);
      if (bcd_valid[0] || bcd_valid[2]) begin
        total++; $display("FAIL rewrite_stray: got %b want 010 or 000", bcd_valid);
      end
    end
    total++; if (vals.size() != 2) $display("FAIL rewrite_count: got %0d want 2", vals.size()); else passed++;
    if (vals.size() == 2) begin
      total++; if (vals[0] !== to_bcd(32'd123)) $display("FAIL rewrite_first: got %h want %h", vals[0], to_bcd(32'd123)); else passed++;
      total++; if (vals[1] !== to_bcd(32'd99)) $display("FAIL rewrite_second: got %h want %h", vals[1], to_bcd(32'd99)); else passed++;
    end
    total++; if (bcd_port1 !== to_bcd(32'd99)) $display("FAIL rewrite_final: got %h want %h", bcd_port1, to_bcd(32'd99)); else passed++;
  endtask

  task automatic test_ignored();
    int pulses = 0;
    int busy_cycles = 0;
    wr(32'h8C, $urandom, 1'b1);
    wr(32'h80, $urandom, 1'b0);
    wr(32'h84, $urandom, 1'b0);
    for (int c = 0; c < 50; c++) begin
      tick();
      if (bcd_valid !== 3'b000) pulses++;
      if (busy) busy_cycles++;
    end
    total++; if (pulses != 0 || busy_cycles != 0) $display("FAIL ignored_activity: got %0d pulses %0d busy want 0 0", pulses, busy_cycles); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_of(k) !== exp_val[k] || bcd_of(k) !== to_bcd(exp_val[k]))
        $display("FAIL ignored_port%0d: got %0d/%h want %0d/%h", k, out_of(k), bcd_of(k), exp_val[k], to_bcd(exp_val[k]));
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int unsigned ch;
      logic [31:0] a, d;
      ch = $urandom_range(0, 4);
      d  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 9999));
      a  = {$urandom, 8'h00};
      a[1:0] = 2'($urandom_range(0, 3));
      a[7:2] = (ch <= 3) ? 6'(6'h20 + ch) : 6'h20;
      wr(a, d, ch != 4);
      repeat ($urandom_range(0, 40)) tick();
    end
    repeat (130) tick();
    total++; if (busy !== 1'b0) $display("FAIL random_idle: got %b want 0", busy); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++; if (out_of(k) !== exp_val[k]) $display("FAIL random_out%0d: got %h want %h", k, out_of(k), exp_val[k]); else passed++;
      total++; if (bcd_of(k) !== to_bcd(exp_val[k])) $display("FAIL random_bcd%0d: got %h want %h", k, bcd_of(k), to_bcd(exp_val[k])); else passed++;
    end
  endtask

  task automatic test_reset_midrun();
    int pulses = 0;
    wr(32'h80, 32'd1234, 1'b1);
    repeat (10) tick();
    resetn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) exp_val[k] = '0;
    total++; if ({out_port0, out_port1, out_port2} !== '0) $display("FAIL midrst_out: got %h want 0", {out_port0, out_port1, out_port2}); else passed++;
    total++; if ({bcd_port0, bcd_port1, bcd_port2} !== '0) $display("FAIL midrst_bcd: got %h want 0", {bcd_port0, bcd_port1, bcd_port2}); else passed++;
    total++; if ({bcd_valid, busy} !== 4'b0) $display("FAIL midrst_valid_busy: got %b want 0000", {bcd_valid, busy}); else passed++;
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bcd_valid !== 3'b000 || busy) pulses++;
    end
    total++; if (pulses != 0) $display("FAIL midrst_after: got %0d active cycles want 0", pulses); else passed++;
    total++; if (bcd_port0 !== '0) $display("FAIL midrst_bcd0: got %h want 0", bcd_port0); else passed++;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) exp_val[k] = '0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    tick();
    test_reset();
    test_single();
    test_max();
    test_back_to_back();
    test_rewrite();
    test_ignored();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
